// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared state encodings, phase codes and grant patterns for the intersection scheduler
// and the display/colour decoders that follow its outputs.
package intersection_phase_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_MAIN_G = 4'd0,
    ST_MAIN_Y = 4'd1,
    ST_RED_A  = 4'd2,
    ST_SIDE_G = 4'd3,
    ST_SIDE_Y = 4'd4,
    ST_PED_W  = 4'd5,
    ST_PED_C  = 4'd6,
    ST_RED_B  = 4'd7,
    ST_EMG    = 4'd8
  } state_t;

  localparam logic [2:0] PH_MAIN_G = 3'd0;
  localparam logic [2:0] PH_MAIN_Y = 3'd1;
  localparam logic [2:0] PH_RED    = 3'd2;
  localparam logic [2:0] PH_SIDE_G = 3'd3;
  localparam logic [2:0] PH_SIDE_Y = 3'd4;
  localparam logic [2:0] PH_PED_W  = 3'd5;
  localparam logic [2:0] PH_PED_C  = 3'd6;
  localparam logic [2:0] PH_EMG    = 3'd7;

  localparam logic [2:0] GR_NONE = 3'b000;
  localparam logic [2:0] GR_MAIN = 3'b001;
  localparam logic [2:0] GR_SIDE = 3'b010;
  localparam logic [2:0] GR_PED  = 3'b100;

  function automatic logic [2:0] phase_of(input state_t s);
    logic [2:0] p;
    p = PH_MAIN_G;
    case (s)
      ST_MAIN_G: p = PH_MAIN_G;
      ST_MAIN_Y: p = PH_MAIN_Y;
      ST_RED_A,
      ST_RED_B:  p = PH_RED;
      ST_SIDE_G: p = PH_SIDE_G;
      ST_SIDE_Y: p = PH_SIDE_Y;
      ST_PED_W:  p = PH_PED_W;
      ST_PED_C:  p = PH_PED_C;
      ST_EMG:    p = PH_EMG;
      default:   p = PH_MAIN_G;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] grant_of(input state_t s);
    logic [2:0] g;
    g = GR_NONE;
    case (s)
      ST_MAIN_G, ST_MAIN_Y: g = GR_MAIN;
      ST_SIDE_G, ST_SIDE_Y: g = GR_SIDE;
      ST_PED_W,  ST_PED_C:  g = GR_PED;
      default:              g = GR_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Right-of-way sequencer for one intersection: main road by default, side road and
// pedestrian served round-robin, emergency pre-emption overriding everything.
//
//  state   | meaning
//  MAIN_G  | main green, waits for pending request once minimum time expired
//  MAIN_Y  | main yellow
//  RED_A   | all red, then picks side or ped
//  SIDE_G  | side green
//  SIDE_Y  | side yellow
//  PED_W   | pedestrian walk
//  PED_C   | pedestrian clearance
//  RED_B   | all red before returning to main
//  EMG     | emergency pre-emption, all red
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MAIN_MIN = 30,
  parameter int unsigned SIDE_GRN = 30,
  parameter int unsigned PED_WALK = 20,
  parameter int unsigned YEL      = 3,
  parameter int unsigned ALL_RED  = 2,
  parameter int unsigned EMG_HOLD = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_side,
  input  logic       req_ped,
  input  logic       emergency,
  output logic [2:0] grant,
  output logic [2:0] phase,
  output logic [7:0] remain
);

  if (TICK_DIV < 2 ||
      MAIN_MIN < 1 || MAIN_MIN > 255 || SIDE_GRN < 1 || SIDE_GRN > 255 ||
      PED_WALK < 1 || PED_WALK > 255 || YEL < 1 || YEL > 255 ||
      ALL_RED < 1 || ALL_RED > 255 || EMG_HOLD < 1 || EMG_HOLD > 255) begin : g_bad_param
    $error("intersection_phase_scheduler: durations must be 1..255 and TICK_DIV >= 2");
  end

  function automatic logic [7:0] dur_of(input state_t s);
    logic [7:0] d;
    d = 8'(MAIN_MIN);
    case (s)
      ST_MAIN_G:            d = 8'(MAIN_MIN);
      ST_MAIN_Y, ST_SIDE_Y,
      ST_PED_C:             d = 8'(YEL);
      ST_RED_A, ST_RED_B:   d = 8'(ALL_RED);
      ST_SIDE_G:            d = 8'(SIDE_GRN);
      ST_PED_W:             d = 8'(PED_WALK);
      ST_EMG:               d = 8'(EMG_HOLD);
      default:              d = 8'(MAIN_MIN);
    endcase
    return d;
  endfunction

  logic       tick;
  state_t     state, state_n;
  logic [7:0] remain_n;
  logic       pend_side, pend_ped, rr_ped;
  logic       enter_side, enter_ped;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    state_n  = state;
    remain_n = remain;
    if (emergency) begin
      state_n  = ST_EMG;
      remain_n = 8'(EMG_HOLD);
    end else if (tick) begin
      if (remain != 8'd1) begin
        remain_n = remain - 8'd1;
      end else begin
        case (state)
          ST_MAIN_G: if (pend_side || pend_ped) state_n = ST_MAIN_Y;
          ST_MAIN_Y: state_n = ST_RED_A;
          ST_RED_A: begin
            if (pend_side && pend_ped) state_n = rr_ped ? ST_PED_W : ST_SIDE_G;
            else if (pend_side)        state_n = ST_SIDE_G;
            else if (pend_ped)         state_n = ST_PED_W;
            else                       state_n = ST_MAIN_G;
          end
          ST_SIDE_G: state_n = ST_SIDE_Y;
          ST_SIDE_Y: state_n = ST_RED_B;
          ST_PED_W:  state_n = ST_PED_C;
          ST_PED_C:  state_n = ST_RED_B;
          ST_RED_B:  state_n = ST_MAIN_G;
          ST_EMG:    state_n = ST_RED_B;
          default:   state_n = ST_MAIN_G;
        endcase
        // MAIN_G with nothing pending stays put and keeps showing 1
        if (state_n != state) remain_n = dur_of(state_n);
      end
    end
  end

  assign enter_side = (state_n == ST_SIDE_G) && (state != ST_SIDE_G);
  assign enter_ped  = (state_n == ST_PED_W)  && (state != ST_PED_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_MAIN_G;
      remain    <= 8'(MAIN_MIN);
      grant     <= GR_MAIN;
      phase     <= PH_MAIN_G;
      pend_side <= 1'b0;
      pend_ped  <= 1'b0;
      rr_ped    <= 1'b0;
    end else begin
      state     <= state_n;
      remain    <= remain_n;
      grant     <= grant_of(state_n);
      phase     <= phase_of(state_n);
      pend_side <= (pend_side | req_side) & ~enter_side;
      pend_ped  <= (pend_ped  | req_ped)  & ~enter_ped;
      if (enter_side)     rr_ped <= 1'b1;
      else if (enter_ped) rr_ped <= 1'b0;
    end
  end

endmodule
